// File: rtl/softmax_sched_pkg.sv
// Shared definitions for the softmax job scheduler: default sizes, length-mode
// encodings and the response-buffer entry layout.
package softmax_sched_pkg;

  localparam int LANES_DEF = 64;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    MODE_0    = 2'd0,
    MODE_1    = 2'd1,
    MODE_2    = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef struct packed {
    logic                           id;
    logic [LANES_DEF*DW_DEF-1:0]    prob;
  } rsp_entry_t;

  // Reserved mode is consumed by the scheduler but never reaches the datapath.
  function automatic logic is_issuable(input logic [1:0] mode);
    return mode_e'(mode) != MODE_RSVD;
  endfunction

endpackage

// File: rtl/softmax_rsp_fifo.sv
// Parameterised synchronous FIFO used for both the tag queue and the response
// buffer; read data is combinational from the head entry and reads as zero when empty.
module softmax_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // A pop frees the slot the same cycle, so push is allowed at full when paired with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/softmax_sched.sv
// Two-requester softmax job scheduler: round-robin admission under a credit limit,
// one-cycle issue register, tag tracking and an in-order response buffer.
module softmax_sched
  import softmax_sched_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,

  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic [LANES*DW-1:0]   req_x_0,
  input  logic [1:0]            req_mode_0,

  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic [LANES*DW-1:0]   req_x_1,
  input  logic [1:0]            req_mode_1,

  output logic                  sm_valid_in,
  output logic [LANES*DW-1:0]   sm_x_flat,
  output logic [1:0]            sm_length_mode,
  output logic                  sm_en,

  input  logic                  sm_valid_out,
  input  logic [LANES*DW-1:0]   sm_prob_flat,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [LANES*DW-1:0]   rsp_prob,

  output logic                  err_mode,
  output logic                  err_orphan,
  output logic                  err_overflow
);

  localparam int VW = LANES * DW;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic          rr_ptr;
  logic [CW-1:0] credits;

  logic          grant_0;
  logic          grant_1;
  logic          can_accept;
  logic          accept;
  logic          win_id;
  logic [1:0]    win_mode;
  logic [VW-1:0] win_x;
  logic          issue;

  logic          tag_push;
  logic          tag_pop;
  logic          tag_rdata;
  logic          tag_empty;
  logic          tag_full;

  logic          rsp_push;
  logic          rsp_pop;
  logic          rsp_empty;
  logic          rsp_full;
  logic [VW:0]   rsp_wdata;
  logic [VW:0]   rsp_rdata;

  // Credits cover both in-flight jobs and buffered responses, so neither FIFO can overflow.
  always_comb begin
    grant_0     = req_valid_0 & (~req_valid_1 | ~rr_ptr);
    grant_1     = req_valid_1 & (~req_valid_0 |  rr_ptr);
    can_accept  = ~rst & en & (credits < CRED_MAX) & ~tag_full;
    req_ready_0 = can_accept & grant_0;
    req_ready_1 = can_accept & grant_1;
    accept      = (req_valid_0 & req_ready_0) | (req_valid_1 & req_ready_1);
    win_id      = req_ready_1;
    win_mode    = win_id ? req_mode_1 : req_mode_0;
    win_x       = win_id ? req_x_1    : req_x_0;
    issue       = accept & is_issuable(win_mode);

    tag_push    = issue;
    tag_pop     = sm_valid_out;
    rsp_push    = sm_valid_out & ~tag_empty;
    rsp_pop     = rsp_valid & rsp_ready;
    rsp_wdata   = {tag_rdata, sm_prob_flat};
  end

  assign sm_en     = en;
  assign rsp_valid = ~rsp_empty;
  assign rsp_id    = rsp_rdata[VW];
  assign rsp_prob  = rsp_rdata[VW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= 1'b0;
      credits <= '0;
    end else begin
      if (accept)
        rr_ptr <= ~win_id;
      case ({issue, rsp_pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Issue register: the datapath sees an accepted job exactly one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_valid_in    <= 1'b0;
      sm_x_flat      <= '0;
      sm_length_mode <= '0;
    end else begin
      sm_valid_in <= issue;
      if (issue) begin
        sm_x_flat      <= win_x;
        sm_length_mode <= win_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_mode     <= 1'b0;
      err_orphan   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_mode     <= err_mode     | (accept & ~is_issuable(win_mode));
      err_orphan   <= err_orphan   | (sm_valid_out & tag_empty);
      err_overflow <= err_overflow | (rsp_push & rsp_full & ~rsp_pop);
    end
  end

  softmax_rsp_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .wdata (win_id),
    .pop   (tag_pop),
    .rdata (tag_rdata),
    .empty (tag_empty),
    .full  (tag_full)
  );

  softmax_rsp_fifo #(
    .WIDTH (VW + 1),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_rdata),
    .empty (rsp_empty),
    .full  (rsp_full)
  );

endmodule

// File: doc/softmax_sched.md
SOFTMAX_SCHED -- requirements
Module: softmax_sched

Interface
REQ-001 Parameter LANES, default 64: number of 16-bit lanes per softmax vector.
REQ-002 Parameter DW, default 16: lane width in bits, signed Q8.8.
REQ-003 Parameter DEPTH, default 8: response-buffer entries, which is also the maximum number of outstanding jobs.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
REQ-005 en  in  1  global enable; when low, no new issue.
REQ-006 Requester ports, for i = 0,1:
- req_valid_i  in  1  job offered.
- req_ready_i  out  1  job accepted this cycle.
- req_x_i  in  LANES*DW  input vector.
- req_mode_i  in  2  length_mode.
REQ-007 Datapath issue ports:
- sm_valid_in  out  1
- sm_x_flat  out  LANES*DW
- sm_length_mode  out  2
- sm_en  out  1
REQ-008 Datapath return ports:
- sm_valid_out  in  1
- sm_prob_flat  in  LANES*DW
REQ-009 Response ports:
- rsp_valid  out  1
- rsp_ready  in  1
- rsp_id  out  1  originating requester.
- rsp_prob  out  LANES*DW
REQ-010 Error ports:
- err_mode  out  1  sticky; reserved mode seen.
- err_orphan  out  1  sticky; result returned with no job outstanding.
- err_overflow  out  1  sticky; response-buffer write attempted while full.

Function
REQ-011 credits counter (0..DEPTH) SHALL count issued-but-unreturned jobs plus buffered responses:
- +1 on an accepted, issued job.
- -1 on rsp_valid & rsp_ready.
- unchanged when both occur in the same cycle.
REQ-012 Arbitration SHALL be 2-way round-robin:
- Pointer resets to requester 0.
- After a grant to requester i, the pointer moves to requester 1-i.
- A lone valid requester is granted regardless of the pointer.
REQ-013 req_ready_i SHALL be asserted only when all of the following hold: en=1, credits<DEPTH, requester i is granted. req_ready_i may depend combinationally on req_valid_*.
REQ-014 Only one requester SHALL be accepted per cycle.
REQ-015 Acceptance with req_mode in {0,1,2}:
- At the next edge, sm_valid_in=1 with sm_x_flat and sm_length_mode taken from the winning port. Issue latency is 1 cycle.
- The requester ID is pushed to the tag FIFO (depth DEPTH).
- credits increments.
REQ-016 Acceptance with req_mode=3:
- The job is consumed.
- Nothing is issued, no tag is pushed and credits is unchanged.
- err_mode is set.
REQ-017 sm_valid_in SHALL be low in every cycle that follows a cycle with no issuing acceptance.
REQ-018 sm_en SHALL equal en.
REQ-019 On sm_valid_out=1:
- The tag FIFO is popped.
- {tag, sm_prob_flat} is written to the response FIFO.
- If the FIFO was empty, rsp_valid rises on the next cycle.
REQ-020 sm_valid_out with the tag FIFO empty SHALL set err_orphan and write nothing.
REQ-021 A response-FIFO write while full SHALL set err_overflow and drop the data. This is unreachable when credits are honoured.
REQ-022 Responses SHALL leave in issue order. rsp_id, rsp_prob and rsp_valid SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 Simultaneous FIFO push and pop SHALL be legal at every occupancy, including full and empty. Read and write pointers wrap modulo DEPTH.
REQ-024 Deasserting en SHALL only stop new acceptances. Returned results and rsp handshakes continue.

Reset
REQ-025 Reset SHALL place every block output and internal register in a known state:
- Outputs low: sm_valid_in, rsp_valid, all req_ready_i, err_mode, err_orphan, err_overflow.
- Data outputs cleared: sm_x_flat, sm_length_mode, rsp_prob and rsp_id all zero.
- Internal state: credits=0, both FIFOs empty, RR pointer = requester 0.
REQ-026 Reset asserted mid-operation SHALL discard all outstanding jobs and buffered responses. A stray sm_valid_out after reset is handled by REQ-020.

Structure
REQ-027 Shared package softmax_sched_pkg SHALL hold:
- LANES, DW and DEPTH defaults.
- Mode encodings: MODE_0=0, MODE_1=1, MODE_2=2, MODE_RSVD=3.
- The response-entry struct {id, prob}.
REQ-028 One sub-module, softmax_rsp_fifo, SHALL be a parameterised synchronous FIFO (width, depth). It SHALL be instantiated twice: once for tags and once for responses.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Single job: req_valid_0 with x={64{16'h061D}}, mode 0 -> sm_valid_in one cycle later; model result returned -> rsp_valid=1, rsp_id=0.
- Contention: both requesters valid every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_id follows the same order.
- Backpressure: rsp_ready=0, 10 jobs offered -> exactly 8 accepted, then req_ready=0; one rsp handshake -> exactly one more accepted.
- Reserved mode: req_mode_1=3 -> accepted, no sm_valid_in, err_mode=1, credits unchanged.
- Orphan: sm_valid_out with no job outstanding -> err_orphan=1, rsp_valid stays 0.
- Mid-run reset: rst pulsed with 3 jobs in flight -> all outputs return to reset values on the same edge and credits=0.
